// File: rtl/dpi_pkg.sv
// Shared types and constants for the DPI stream dispatcher and its stream table.
package dpi_pkg;

    localparam int unsigned NUM_STREAMS = 64;
    localparam int unsigned STREAM_ID_W = 6;

    localparam int unsigned DEF_NUM_CAT     = 8;
    localparam int unsigned DEF_RESTORE_LAT = 2;
    localparam int unsigned DEF_DRAIN_LAT   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StStream,
        StDrain,
        StFin,
        StReport
    } dpi_disp_state_t;

endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream state: seen bitmap and per-category enable RAM.
module dpi_stream_table
    import dpi_pkg::*;
#(
    parameter int unsigned NUM_CAT = DEF_NUM_CAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [STREAM_ID_W-1:0] lookup_id,
    output logic                   lookup_seen,
    output logic [NUM_CAT-1:0]     lookup_enable,
    input  logic                   set_seen,
    input  logic                   clear_seen,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_addr,
    input  logic [NUM_CAT-1:0]     cfg_wdata
);

    logic [NUM_STREAMS-1:0] seen_q;
    logic [NUM_CAT-1:0]     en_q [NUM_STREAMS];

    assign lookup_seen   = seen_q[lookup_id];
    assign lookup_enable = en_q[lookup_id];

    // Clear takes priority so a clear coinciding with the LOAD-cycle set leaves the bit at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else if (clear_seen) begin
            seen_q <= '0;
        end else if (set_seen) begin
            seen_q[lookup_id] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_STREAMS); i++) begin
                en_q[i] <= '0;
            end
        end else if (cfg_we) begin
            en_q[cfg_addr] <= cfg_wdata;
        end
    end

endmodule

// File: rtl/dpi_stream_dispatcher.sv
// Sequences restore / stream / finalize for the regex matcher bank, one packet at a time,
// and emits one fired-flag result record per packet.
module dpi_stream_dispatcher
    import dpi_pkg::*;
#(
    parameter int unsigned NUM_CAT     = DEF_NUM_CAT,
    parameter int unsigned RESTORE_LAT = DEF_RESTORE_LAT,
    parameter int unsigned DRAIN_LAT   = DEF_DRAIN_LAT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             pkt_data,
    input  logic                   pkt_vld,
    input  logic                   pkt_sop,
    input  logic                   pkt_eop,
    input  logic [STREAM_ID_W-1:0] pkt_stream_id,
    output logic                   pkt_rdy,
    input  logic                   cfg_we,
    input  logic [STREAM_ID_W-1:0] cfg_addr,
    input  logic [NUM_CAT-1:0]     cfg_wdata,
    input  logic                   clear_streams,
    output logic [STREAM_ID_W-1:0] stream_id,
    output logic                   new_stream_id,
    output logic                   load_state,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   eop,
    output logic [NUM_CAT-1:0]     enable,
    input  logic [NUM_CAT-1:0]     fired,
    output logic                   res_vld,
    output logic [STREAM_ID_W-1:0] res_stream_id,
    output logic [NUM_CAT-1:0]     res_fired
);

    // char_in is registered, so WAIT is one cycle shorter than the restore gap it produces.
    localparam logic [7:0] WaitLast  = (RESTORE_LAT > 1) ? 8'(RESTORE_LAT - 2) : 8'd0;
    localparam logic [7:0] DrainLast = 8'(DRAIN_LAT);

    dpi_disp_state_t        state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [STREAM_ID_W-1:0] sid_q;
    logic [NUM_CAT-1:0]     en_q;
    logic [7:0]             char_q;
    logic                   char_vld_q;
    logic                   set_seen;
    logic                   lookup_seen;
    logic [NUM_CAT-1:0]     lookup_enable;
    logic                   accept_char;

    dpi_stream_table #(
        .NUM_CAT(NUM_CAT)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_id    (sid_q),
        .lookup_seen  (lookup_seen),
        .lookup_enable(lookup_enable),
        .set_seen     (set_seen),
        .clear_seen   (clear_streams),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata)
    );

    assign accept_char = (state_q == StStream) && pkt_vld;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pkt_rdy    = 1'b0;
        load_state = 1'b0;
        set_seen   = 1'b0;
        eop        = 1'b0;
        res_vld    = 1'b0;
        case (state_q)
            StIdle: begin
                if (pkt_vld && pkt_sop) begin
                    state_d = StLoad;
                end else if (pkt_vld) begin
                    pkt_rdy = 1'b1;
                end
            end
            StLoad: begin
                load_state = 1'b1;
                set_seen   = 1'b1;
                cnt_d      = '0;
                state_d    = (RESTORE_LAT > 1) ? StWait : StStream;
            end
            StWait: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == WaitLast) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                pkt_rdy = 1'b1;
                if (pkt_vld && pkt_eop) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == DrainLast) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                eop     = 1'b1;
                state_d = StReport;
            end
            StReport: begin
                res_vld = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        enable = '0;
        case (state_q)
            StLoad:                                      enable = lookup_enable;
            StWait, StStream, StDrain, StFin, StReport:  enable = en_q;
            default:                                     enable = '0;
        endcase
    end

    assign stream_id     = sid_q;
    assign new_stream_id = load_state & ~lookup_seen;
    assign char_in       = char_q;
    assign char_in_vld   = char_vld_q;
    assign res_stream_id = res_vld ? sid_q : '0;
    assign res_fired     = res_vld ? (fired & en_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sid_q      <= '0;
            en_q       <= '0;
            char_q     <= '0;
            char_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            char_vld_q <= accept_char;
            if (state_q == StIdle && pkt_vld && pkt_sop) begin
                sid_q <= pkt_stream_id;
            end
            if (state_q == StLoad) begin
                en_q <= lookup_enable;
            end
            if (accept_char) begin
                char_q <= pkt_data;
            end
        end
    end

endmodule

// File: tb/tb_dpi_stream_dispatcher.sv
// Scoreboard bench for dpi_stream_dispatcher: driver pushes expected records, monitor checks them.
module tb_dpi_stream_dispatcher;

    localparam int RL = 2;
    localparam int DL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pkt_data;
    logic       pkt_vld, pkt_sop, pkt_eop;
    logic [5:0] pkt_stream_id;
    logic       pkt_rdy;
    logic       cfg_we;
    logic [5:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       clear_streams;
    logic [5:0] stream_id;
    logic       new_stream_id, load_state;
    logic [7:0] char_in;
    logic       char_in_vld, eop;
    logic [7:0] enable, fired;
    logic       res_vld;
    logic [5:0] res_stream_id;
    logic [7:0] res_fired;

    dpi_stream_dispatcher #(
        .NUM_CAT    (8),
        .RESTORE_LAT(RL),
        .DRAIN_LAT  (DL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pkt_data     (pkt_data),
        .pkt_vld      (pkt_vld),
        .pkt_sop      (pkt_sop),
        .pkt_eop      (pkt_eop),
        .pkt_stream_id(pkt_stream_id),
        .pkt_rdy      (pkt_rdy),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .clear_streams(clear_streams),
        .stream_id    (stream_id),
        .new_stream_id(new_stream_id),
        .load_state   (load_state),
        .char_in      (char_in),
        .char_in_vld  (char_in_vld),
        .eop          (eop),
        .enable       (enable),
        .fired        (fired),
        .res_vld      (res_vld),
        .res_stream_id(res_stream_id),
        .res_fired    (res_fired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] sid;
        logic       nw;
        logic [7:0] en;
        logic [7:0] n;
    } load_t;

    load_t       exp_load [$];
    logic [7:0]  exp_char [$];
    logic [13:0] exp_res  [$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor / scoreboard
    logic  pkt_open = 1'b0;
    load_t cur;
    int    nchar, load_cyc, last_cyc, eop_cyc;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pkt_open = 1'b0;
            exp_load.delete();
            exp_char.delete();
            exp_res.delete();
        end else begin
            if (!pkt_open && pkt_vld && pkt_sop) check("rdy_low_on_sop_outside_stream", pkt_rdy, 0);
            if (load_state) begin
                if (pkt_open) flag("second_load_state");
                if (exp_load.size() == 0) begin
                    flag("unexpected_load_state");
                end else begin
                    cur = exp_load.pop_front();
                    check("load_stream_id", stream_id, cur.sid);
                    check("new_stream_id", new_stream_id, cur.nw);
                    check("enable_at_load", enable, cur.en);
                    pkt_open = 1'b1;
                    nchar    = 0;
                    load_cyc = cyc;
                end
            end else if (pkt_open) begin
                check("enable_held", enable, cur.en);
            end
            if (char_in_vld) begin
                if (!pkt_open) begin
                    flag("char_in_vld_outside_packet");
                end else begin
                    if (nchar == 0) check("restore_gap", cyc - load_cyc, RL + 1);
                    if (exp_char.size() == 0) flag("extra_char");
                    else check("char_in", char_in, exp_char.pop_front());
                    nchar++;
                    last_cyc = cyc;
                end
            end
            if (eop) begin
                if (!pkt_open) begin
                    flag("eop_outside_packet");
                end else begin
                    check("char_count", nchar, cur.n);
                    check("drain_gap", cyc - last_cyc, DL + 1);
                    eop_cyc = cyc;
                end
            end
            if (res_vld) begin
                if (!pkt_open || exp_res.size() == 0) begin
                    flag("unexpected_res_vld");
                end else begin
                    logic [13:0] r;
                    r = exp_res.pop_front();
                    check("res_stream_id", res_stream_id, r[13:8]);
                    check("res_fired", res_fired, r[7:0]);
                    check("report_after_fin", cyc - eop_cyc, 1);
                end
                pkt_open = 1'b0;
            end
        end
    end

    // Driver
    task automatic beat();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (pkt_rdy) break;
        end
        if (k == 200) flag("pkt_rdy_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        pkt_vld = 1'b0;
        pkt_sop = 1'b0;
        pkt_eop = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_pkt(input logic [5:0] sid, input logic nw, input logic [7:0] en,
                            input logic [7:0] res, input int n, input logic [63:0] bytes);
        load_t r;
        r.sid = sid;
        r.nw  = nw;
        r.en  = en;
        r.n   = 8'(n);
        exp_load.push_back(r);
        for (int i = 0; i < n; i++) exp_char.push_back(bytes[8*i +: 8]);
        exp_res.push_back({sid, res});
        for (int i = 0; i < n; i++) begin
            pkt_vld       = 1'b1;
            pkt_sop       = (i == 0);
            pkt_eop       = (i == n - 1);
            pkt_data      = bytes[8*i +: 8];
            pkt_stream_id = (i == 0) ? sid : 6'h3F;
            beat();
        end
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_load.size() == 0 && exp_res.size() == 0 && !pkt_open) break;
        end
        if (k == 300) flag("packet_completion_timeout");
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return 64'({pkt_rdy, stream_id, new_stream_id, load_state, char_in, char_in_vld, eop,
                    enable, res_vld, res_stream_id, res_fired});
    endfunction

    initial begin
        rst_n = 1'b0;
        idle_in();
        pkt_data = '0; pkt_stream_id = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        clear_streams = 1'b0;
        fired = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;

        cfg_write(6'd5, 8'hFF);
        cfg_write(6'd1, 8'h0F);
        cfg_write(6'd2, 8'hF0);
        cfg_write(6'd7, 8'h3C);
        cfg_write(6'd3, 8'h05);

        // 1: first packet on stream 5
        send_pkt(6'd5, 1'b1, 8'hFF, 8'hFF, 4, 64'h44434241);
        idle_in();
        wait_drain();

        // 2: seen stream, then clear
        send_pkt(6'd5, 1'b0, 8'hFF, 8'hFF, 2, 64'h0201);
        idle_in();
        wait_drain();
        clear_streams = 1'b1;
        @(posedge clk);
        #1;
        clear_streams = 1'b0;
        send_pkt(6'd5, 1'b1, 8'hFF, 8'hFF, 2, 64'h0403);
        idle_in();
        wait_drain();

        // 3: masked enable; a write to the in-flight stream must not disturb it
        send_pkt(6'd3, 1'b1, 8'h05, 8'h05, 3, 64'hC3B2A1);
        idle_in();
        cfg_write(6'd3, 8'hAA);
        wait_drain();

        // Stray byte in IDLE is accepted and dropped
        pkt_vld = 1'b1; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = 8'hEE;
        beat();
        idle_in();
        repeat (5) @(posedge clk);
        #1;

        // 4: single-byte packet
        send_pkt(6'd7, 1'b1, 8'h3C, 8'h3C, 1, 64'h7A);
        idle_in();
        wait_drain();

        // 5: back-to-back with pkt_vld held
        fired = 8'h5A;
        send_pkt(6'd1, 1'b1, 8'h0F, 8'h0A, 3, 64'h131211);
        send_pkt(6'd2, 1'b1, 8'hF0, 8'h50, 5, 64'h2524232221);
        idle_in();
        wait_drain();

        // 6: reset mid-STREAM
        begin
            load_t r;
            r.sid = 6'd9; r.nw = 1'b1; r.en = 8'h00; r.n = 8'd4;
            exp_load.push_back(r);
            exp_char.push_back(8'h10);
            exp_char.push_back(8'h11);
        end
        pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_data = 8'h10; pkt_stream_id = 6'd9;
        beat();
        pkt_sop = 1'b0; pkt_data = 8'h11;
        beat();
        pkt_data = 8'h12;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        idle_in();
        #1;
        check("async_reset_outputs", outs(), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send_pkt(6'd9, 1'b1, 8'h00, 8'h00, 2, 64'h3231);
        idle_in();
        wait_drain();

        check("leftover_load", exp_load.size(), 0);
        check("leftover_char", exp_char.size(), 0);
        check("leftover_res", exp_res.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dpi_stream_dispatcher.md
Name: dpi_stream_dispatcher

Overview:
- Front-end sequencer that drives the bank of per-category regex matcher wrappers in the DPI core.
- Accepts packet bytes from upstream with a valid/ready handshake. Tracks which stream IDs have been seen, and issues the restore/stream/finalize protocol: stream_id, new_stream_id, load_state, char_in, char_in_vld, eop, enable.
- After each packet it collects the matchers' fired flags and emits one result record per packet.

Parameters:
- NUM_CAT, 8, number of category matchers; width of enable and fired vectors.
- RESTORE_LAT, 2, idle cycles between the load_state pulse and the first char_in_vld; covers the state-memory read plus the matcher state load.
- DRAIN_LAT, 2, idle cycles between the last char_in_vld and the eop pulse; covers matcher accept pipeline.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pkt_data  in  8  upstream byte
- pkt_vld  in  1  upstream byte valid
- pkt_sop  in  1  first byte of packet, qualified by pkt_vld
- pkt_eop  in  1  last byte of packet, qualified by pkt_vld
- pkt_stream_id  in  6  stream ID, sampled only on the sop beat
- pkt_rdy  out  1  dispatcher accepts the current byte
- cfg_we  in  1  enable-mask write strobe
- cfg_addr  in  6  stream ID being configured
- cfg_wdata  in  NUM_CAT  per-category enable mask
- clear_streams  in  1  single-cycle pulse; forget all seen streams
- stream_id  out  6  current stream, to matchers
- new_stream_id  out  1  stream not seen since reset/clear; valid with load_state
- load_state  out  1  one-cycle restore pulse
- char_in  out  8  byte to matchers
- char_in_vld  out  1  char_in valid
- eop  out  1  one-cycle finalize pulse
- enable  out  NUM_CAT  per-category enable for the current stream; held from LOAD through REPORT
- fired  in  NUM_CAT  per-category fired flags from the matchers
- res_vld  out  1  one-cycle result strobe
- res_stream_id  out  6  stream of the reported packet
- res_fired  out  NUM_CAT  fired & enable, captured in REPORT

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - Seen bitmap (64 bits) and enable table (64 x NUM_CAT) are cleared.
  - All outputs are 0.
  - Reset mid-packet abandons the packet; no eop and no result are issued.
- FSM states: IDLE, LOAD, WAIT, STREAM, DRAIN, FIN, REPORT.
- IDLE:
  - pkt_rdy=0.
  - On pkt_vld&pkt_sop: latch pkt_stream_id into stream_id, go to LOAD. The sop byte is NOT consumed in this state.
  - pkt_vld without sop: pkt_rdy=1, the byte is dropped, and the stray-byte condition is ignored.
- LOAD (one cycle):
  - load_state=1.
  - new_stream_id = ~seen[stream_id].
  - Latch enable from enable_table[stream_id].
  - Set seen[stream_id]=1.
  - Go to WAIT.
- WAIT: count RESTORE_LAT cycles, then go to STREAM. If RESTORE_LAT=0, go straight to STREAM.
- STREAM:
  - pkt_rdy=1.
  - On pkt_vld: char_in<=pkt_data and char_in_vld<=1, registered with 1-cycle latency.
  - On a beat with pkt_eop: go to DRAIN. The sop beat is the first char; a single-byte packet (sop&eop) is legal.
  - A second sop inside STREAM is treated as data.
- DRAIN:
  - pkt_rdy=0.
  - Wait DRAIN_LAT cycles after the final char_in_vld.
- FIN: eop=1 for exactly one cycle; enable still driven.
- REPORT (the cycle after FIN):
  - res_fired = fired & enable; res_stream_id = stream_id; res_vld=1.
  - Return to IDLE. At most one packet is in flight.
- Protocol invariants:
  - Exactly one load_state and one eop per accepted packet.
  - char_in_vld is never asserted outside STREAM+1 cycle.
  - Minimum per-packet overhead: 1+RESTORE_LAT+DRAIN_LAT+2 cycles.
- cfg_we:
  - Writes enable_table[cfg_addr] at any time.
  - A write to the in-flight stream does not affect the enable value already latched in LOAD.
- clear_streams: clears the whole seen bitmap. If it coincides with the LOAD-cycle set, clear wins, so seen[stream_id] ends 0.
- Bitmap indexing wraps naturally on 6 bits; no out-of-range case exists.

Decomposition:
- Shared package dpi_pkg holds:
  - NUM_STREAMS=64 and STREAM_ID_W=6
  - the FSM state enum dpi_disp_state_t
  - default latency constants
- Sub-module dpi_stream_table: the seen bitmap plus the enable RAM, with a lookup port, set, clear and cfg write. All other logic stays inline.

Test Plan:
1. Reset, then a 4-byte packet (stream 5, bytes 0x41..0x44, enable table 0xFF) -> load_state=1 with new_stream_id=1. 4 char_in_vld beats start exactly RESTORE_LAT+1 cycles after load_state. eop comes DRAIN_LAT+1 cycles after the last char. Then res_vld with res_stream_id=5.
2. Second packet on stream 5 -> new_stream_id=0. Then clear_streams, third packet on stream 5 -> new_stream_id=1.
3. cfg_we addr=3 data=0x05; packet on stream 3 with fired=0xFF in REPORT -> enable=0x05 held from LOAD through FIN, res_fired=0x05.
4. Single-byte packet (sop&eop, data 0x7A) -> exactly one char_in_vld, one load_state, one eop, one res_vld.
5. pkt_vld held continuously, with back-to-back packets on streams 1 and 2 -> pkt_rdy low outside STREAM. No byte is lost or duplicated; byte count per packet matches input.
6. rst_n asserted mid-STREAM -> all outputs 0 asynchronously; no eop or res_vld follows. The next packet on the same stream reports new_stream_id=1.
